cook_controller: RTL and testbench

Sequencing FSM for the microwave cook timer. It turns keypad strobes into load pulses for the minutes/seconds timer datapath, and gates the timer's 1 Hz count enable while cooking. It tracks the door and start/stop buttons, drives the magnetron, and produces a timed "done" indication when the timer reaches zero. It sits between the debounced front-panel inputs and the timer datapath, one level above it.

---
 rtl/cook_pkg.sv | 18 +
 rtl/done_tick_counter.sv | 36 +++
 rtl/cook_controller.sv | 140 ++++++++++++++
 tb/tb_cook_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared constants for the microwave cook controller: FSM state encodings and
// keypad limits used by the controller and its helper blocks.
package cook_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] MAX_DIGITS = 2'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/done_tick_counter.sv
// Counts 1 Hz ticks while the cook-complete indication is shown; terminal
// fires combinationally on the tick that reaches DONE_TICKS.
module done_tick_counter #(
  parameter int DONE_TICKS = 3
) (
  input  logic clock,
  input  logic clrn,
  input  logic clr,
  input  logic tick,
  output logic terminal
);

  localparam int W = $clog2(DONE_TICKS + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign terminal = tick && !clr && (cnt_q == W'(DONE_TICKS - 1));

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cook_controller.sv
// Microwave cook sequencing FSM: keypad digits become timer load pulses, the
// 1 Hz enable is gated while cooking, and a timed done indication follows zero.
module cook_controller
  import cook_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  logic [2:0] state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [3:0] timer_data_q, timer_data_d;
  logic       timer_loadn_q, timer_loadn_d;
  logic       timer_clrn_q, timer_clrn_d;
  logic       mag_on_q, mag_on_d;
  logic       done_q, done_d;
  logic       key_ok;
  logic       dt_clr;
  logic       dt_terminal;

  assign key_ok = key_valid && is_bcd(key_digit);
  assign dt_clr = (state_q != ST_DONE);

  done_tick_counter #(.DONE_TICKS(DONE_TICKS)) u_done_ticks (
    .clock    (clock),
    .clrn     (clrn),
    .clr      (dt_clr),
    .tick     (tick),
    .terminal (dt_terminal)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    timer_data_d  = timer_data_q;
    timer_loadn_d = 1'b1;
    timer_clrn_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (key_ok) begin
          timer_data_d  = key_digit;
          timer_loadn_d = 1'b0;
          count_d       = 2'd1;
          state_d       = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop) begin
          timer_clrn_d = 1'b0;
          count_d      = 2'd0;
          state_d      = ST_IDLE;
        end else begin
          if (key_ok && (count_q < MAX_DIGITS)) begin
            timer_data_d  = key_digit;
            timer_loadn_d = 1'b0;
            count_d       = count_q + 2'd1;
          end
          if (start && door_closed && !timer_zero) begin
            state_d = ST_COOK;
          end
        end
      end
      ST_COOK: begin
        // Reaching zero wins over stop/door so the done indication is never lost.
        if (timer_zero) begin
          state_d = ST_DONE;
        end else if (stop || !door_closed) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          timer_clrn_d = 1'b0;
          count_d      = 2'd0;
          state_d      = ST_IDLE;
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop || key_valid || dt_terminal) begin
          count_d = 2'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        count_d = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
    mag_on_d = (state_d == ST_COOK);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      count_q       <= 2'd0;
      timer_data_q  <= 4'd0;
      timer_loadn_q <= 1'b1;
      timer_clrn_q  <= 1'b0;
      mag_on_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_data_q  <= timer_data_d;
      timer_loadn_q <= timer_loadn_d;
      timer_clrn_q  <= timer_clrn_d;
      mag_on_q      <= mag_on_d;
      done_q        <= done_d;
    end
  end

  // Enable is the only combinational output so a tick reaches the timer in its own cycle.
  assign timer_enable = tick && (state_q == ST_COOK);
  assign timer_data   = timer_data_q;
  assign timer_loadn  = timer_loadn_q;
  assign timer_clrn   = timer_clrn_q;
  assign mag_on       = mag_on_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cook_controller.sv
// Directed vector bench for cook_controller: a table of per-cycle inputs with
// hand-computed outputs, plus hand-written reset sequences.
module tb_cook_controller;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b0;
  logic       tick = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clrn;
  logic       timer_enable;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       door;
    logic       tk;
    logic       tz;
    logic       en;
    logic [2:0] state;
    logic       loadn;
    logic [3:0] data;
    logic       clrn;
    logic       mag;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  cook_controller #(.DONE_TICKS(3)) dut (
    .clock        (clock),
    .clrn         (clrn),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .tick         (tick),
    .timer_zero   (timer_zero),
    .timer_data   (timer_data),
    .timer_loadn  (timer_loadn),
    .timer_clrn   (timer_clrn),
    .timer_enable (timer_enable),
    .mag_on       (mag_on),
    .done         (done),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                     input logic door, input logic tk, input logic tz, input logic en,
                     input logic [2:0] s, input logic loadn, input logic [3:0] data,
                     input logic c, input logic mag, input logic dn);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.door = door; v.tk = tk; v.tz = tz;
    v.en = en; v.state = s; v.loadn = loadn; v.data = data; v.clrn = c; v.mag = mag; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, -1, {1'b0, state}, {1'b0, S_IDLE});
    check({tag, "_data"}, -1, timer_data, 4'd0);
    check({tag, "_loadn"}, -1, {3'b0, timer_loadn}, 4'd1);
    check({tag, "_clrn"}, -1, {3'b0, timer_clrn}, 4'd0);
    check({tag, "_en"}, -1, {3'b0, timer_enable}, 4'd0);
    check({tag, "_mag"}, -1, {3'b0, mag_on}, 4'd0);
    check({tag, "_done"}, -1, {3'b0, done}, 4'd0);
  endtask

  initial begin
    //  kv kd   st sp dr tk tz | en state   ld data cl mg dn
    add(0, 0,   0, 0, 0, 0, 0,  0, S_IDLE,  1, 0,   1, 0, 0);
    add(1, 12,  0, 0, 0, 0, 0,  0, S_IDLE,  1, 0,   1, 0, 0);
    add(0, 0,   1, 1, 1, 0, 0,  0, S_IDLE,  1, 0,   1, 0, 0);
    add(1, 1,   0, 0, 0, 0, 0,  0, S_ENTRY, 0, 1,   1, 0, 0);
    add(1, 3,   0, 0, 0, 0, 0,  0, S_ENTRY, 0, 3,   1, 0, 0);
    add(0, 0,   0, 0, 0, 0, 0,  0, S_ENTRY, 1, 3,   1, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0,  0, S_ENTRY, 0, 0,   1, 0, 0);
    add(1, 5,   0, 0, 0, 0, 0,  0, S_ENTRY, 1, 0,   1, 0, 0);
    add(0, 0,   1, 0, 0, 0, 0,  0, S_ENTRY, 1, 0,   1, 0, 0);
    add(0, 0,   1, 0, 1, 1, 0,  0, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 1, 0,  1, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 0, 0,  0, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 1, 0,  1, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 1, 0,  1, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 1, 0,  1, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 1, 1, 0,  1, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 0, 0, 0,  0, S_PAUSE, 1, 0,   1, 0, 0);
    add(0, 0,   0, 0, 0, 1, 0,  0, S_PAUSE, 1, 0,   1, 0, 0);
    add(0, 0,   1, 0, 0, 0, 0,  0, S_PAUSE, 1, 0,   1, 0, 0);
    add(0, 0,   1, 0, 1, 0, 0,  0, S_COOK,  1, 0,   1, 1, 0);
    add(1, 6,   0, 0, 1, 0, 0,  0, S_COOK,  1, 0,   1, 1, 0);
    add(0, 0,   0, 0, 0, 0, 1,  0, S_DONE,  1, 0,   1, 0, 1);
    add(0, 0,   0, 0, 0, 1, 1,  0, S_DONE,  1, 0,   1, 0, 1);
    add(0, 0,   0, 0, 0, 0, 1,  0, S_DONE,  1, 0,   1, 0, 1);
    add(0, 0,   0, 0, 0, 1, 1,  0, S_DONE,  1, 0,   1, 0, 1);
    add(0, 0,   0, 0, 0, 1, 1,  0, S_IDLE,  1, 0,   1, 0, 0);
    add(1, 2,   0, 0, 0, 0, 0,  0, S_ENTRY, 0, 2,   1, 0, 0);
    add(0, 0,   0, 1, 0, 0, 0,  0, S_IDLE,  1, 2,   0, 0, 0);
    add(0, 0,   0, 0, 0, 0, 0,  0, S_IDLE,  1, 2,   1, 0, 0);
    add(1, 4,   0, 0, 0, 0, 0,  0, S_ENTRY, 0, 4,   1, 0, 0);
    add(0, 0,   1, 0, 1, 0, 0,  0, S_COOK,  1, 4,   1, 1, 0);
    add(0, 0,   0, 1, 1, 0, 0,  0, S_PAUSE, 1, 4,   1, 0, 0);
    add(0, 0,   1, 1, 1, 0, 0,  0, S_IDLE,  1, 4,   0, 0, 0);
    add(0, 0,   0, 0, 1, 0, 0,  0, S_IDLE,  1, 4,   1, 0, 0);
    add(1, 7,   0, 0, 1, 0, 0,  0, S_ENTRY, 0, 7,   1, 0, 0);
    add(0, 0,   1, 0, 1, 0, 0,  0, S_COOK,  1, 7,   1, 1, 0);
    add(0, 0,   0, 1, 1, 0, 1,  0, S_DONE,  1, 7,   1, 0, 1);
    add(1, 8,   0, 0, 1, 0, 1,  0, S_IDLE,  1, 7,   1, 0, 0);
    add(1, 9,   0, 0, 1, 0, 0,  0, S_ENTRY, 0, 9,   1, 0, 0);
    add(1, 1,   0, 0, 1, 0, 0,  0, S_ENTRY, 0, 1,   1, 0, 0);
    add(1, 2,   0, 0, 1, 0, 0,  0, S_ENTRY, 0, 2,   1, 0, 0);
    add(1, 3,   0, 0, 1, 0, 0,  0, S_ENTRY, 1, 2,   1, 0, 0);
    add(0, 0,   1, 0, 1, 0, 1,  0, S_ENTRY, 1, 2,   1, 0, 0);
    add(0, 0,   1, 0, 1, 0, 0,  0, S_COOK,  1, 2,   1, 1, 0);

    // Reset held: every output at its reset value.
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");

    @(negedge clock);
    clrn = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clock);
      key_valid = vecs[i].kv; key_digit = vecs[i].kd; start = vecs[i].st; stop = vecs[i].sp;
      door_closed = vecs[i].door; tick = vecs[i].tk; timer_zero = vecs[i].tz;
      #1;
      check("enable", i, {3'b0, timer_enable}, {3'b0, vecs[i].en});
      @(posedge clock);
      #1;
      check("state", i, {1'b0, state}, {1'b0, vecs[i].state});
      check("loadn", i, {3'b0, timer_loadn}, {3'b0, vecs[i].loadn});
      check("data", i, timer_data, vecs[i].data);
      check("tclrn", i, {3'b0, timer_clrn}, {3'b0, vecs[i].clrn});
      check("mag_on", i, {3'b0, mag_on}, {3'b0, vecs[i].mag});
      check("done", i, {3'b0, done}, {3'b0, vecs[i].done});
    end

    // Reset mid-COOK between edges: outputs must drop without waiting for a clock.
    @(negedge clock);
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;
    tick = 1'b1;
    #1;
    check("cook_en_pre_rst", -1, {3'b0, timer_enable}, 4'd1);
    clrn = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick = 1'b0;
    @(negedge clock);
    clrn = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_tclrn", -1, {3'b0, timer_clrn}, 4'd1);
    check("post_rst_state", -1, {1'b0, state}, {1'b0, S_IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
